// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - opcode constants, fetch entry type and immediate helpers shared with decode
package fetch_unit_pkg;

    localparam int LEN_INST = 32;
    localparam int LEN_WORD = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [LEN_INST-1:0] inst;
        logic [LEN_WORD-1:0] pc;
        logic                pred;
    } fetch_entry_t;

    // B-format and J-format byte offsets, sign-extended to a full word
    function automatic logic [LEN_WORD-1:0] imm13(input logic [LEN_INST-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [LEN_WORD-1:0] imm21(input logic [LEN_INST-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {inst, pc, pred} entries with flush
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is reset so the head reads as zero straight out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, imem reads, output FIFO, redirect flush
// FETCH_BTFN_EN enables static backward-taken/forward-not-taken prediction at enqueue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_AW     = 14,
    parameter int          MEM_LATENCY = 1,
    parameter int          DEPTH       = 4
)(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [31:0]        out_pc,
    output logic               out_pred_taken
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]            pc_fetch;
    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [31:0]            pipe_pc [MEM_LATENCY];
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          inflight_count;
    logic                   credit_ok;
    logic                   issue;
    logic                   enq;
    logic                   pop;
    logic                   predict_taken;
    fetch_entry_t           enq_entry;
    fetch_entry_t           head;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_count = inflight_count + CW'(pipe_valid[i]);
        end
    end

    // Every in-flight read owns a FIFO slot, so the FIFO can never overflow
    assign credit_ok = (fifo_count + inflight_count) < CW'(DEPTH);
    assign issue     = credit_ok && !redirect_valid && !predict_taken && !rst;
    assign imem_en   = issue;
    assign imem_addr = issue ? pc_fetch[IMEM_AW+1:2] : '0;

`ifdef FETCH_BTFN_EN
    logic [31:0] predict_target;

    always_comb begin
        predict_taken  = 1'b0;
        predict_target = pipe_pc[MEM_LATENCY-1] + imm21(imem_rdata);
        if (pipe_valid[MEM_LATENCY-1]) begin
            if (imem_rdata[6:0] == OP_JAL) begin
                predict_taken = 1'b1;
            end else if (imem_rdata[6:0] == OP_BRANCH && imem_rdata[31]) begin
                predict_taken  = 1'b1;
                predict_target = pipe_pc[MEM_LATENCY-1] + imm13(imem_rdata);
            end
        end
    end
`else
    assign predict_taken = 1'b0;
`endif

    assign enq            = pipe_valid[MEM_LATENCY-1] && !redirect_valid;
    assign enq_entry.inst = imem_rdata;
    assign enq_entry.pc   = pipe_pc[MEM_LATENCY-1];
    assign enq_entry.pred = predict_taken;
    assign pop            = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_fetch   <= RESET_PC;
            pipe_valid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_pc[i] <= '0;
            end
        end else begin
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_pc[i]    <= pipe_pc[i-1];
            end
            pipe_valid[0] <= issue;
            pipe_pc[0]    <= pc_fetch;
            // External redirect outranks a prediction made in the same cycle
            if (redirect_valid) begin
                pipe_valid <= '0;
                pc_fetch   <= redirect_pc & ~32'd3;
            end else if (predict_taken) begin
`ifdef FETCH_BTFN_EN
                pipe_valid <= '0;
                pc_fetch   <= predict_target;
`endif
            end else if (issue) begin
                pc_fetch <= pc_fetch + 32'd4;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (enq),
        .wr_data (enq_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign out_valid      = (fifo_count != '0);
    assign out_inst       = head.inst;
    assign out_pc         = head.pc;
    assign out_pred_taken = head.pred;

endmodule
